// File: rtl/ps2_key_dev_tx.sv
// ps2_key_dev_tx
//   Turns hps_io ps2_key toggle events into a device-side PS/2 keyboard stream
//   (Set-2 make/break sequences), clocked and framed like a real keyboard.
//   Host inhibit (clock held low) aborts the current frame; the byte is resent whole.
// Ports
//   clk_sys       core clock, rising edge
//   reset_n       async active-low reset
//   ps2_key[10:0] [10] toggle strobe, [9] pressed, [8] extended, [7:0] scancode
//   ps2_clk_in    sensed PS/2 clock line (0 = host inhibit)
//   ps2_data_in   sensed PS/2 data line (0 with clock high = host request-to-send)
//   ps2_clk_out   device clock drive, 1 = released
//   ps2_data_out  device data drive, 1 = released
//   busy          frame in progress or bytes queued
//   overflow      one-cycle pulse when an event is dropped
module ps2_key_dev_tx #(
  parameter int CLK_DIV = 1000,
  parameter int HOLDOFF = 2000,
  parameter int FIFO_AW = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_out,
  output logic        ps2_data_out,
  output logic        busy,
  output logic        overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DW    = $clog2(CLK_DIV + 1);
  localparam int HW    = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {S_IDLE, S_HIGH, S_LOW, S_GAP, S_ABORT} state_t;

  // Byte sequence for one key event; bytes[7:0] goes out first.
  typedef struct packed {
    logic [1:0]  len;
    logic [23:0] bytes;
  } ev_seq_t;

  function automatic ev_seq_t mk_seq(input logic ext, input logic prs, input logic [7:0] code);
    ev_seq_t s;
    case ({ext, prs})
      2'b10:   begin s.len = 2'd3; s.bytes = {code, 8'hF0, 8'hE0};  end
      2'b11:   begin s.len = 2'd2; s.bytes = {8'h00, code, 8'hE0}; end
      2'b00:   begin s.len = 2'd2; s.bytes = {8'h00, code, 8'hF0}; end
      default: begin s.len = 2'd1; s.bytes = {16'h0000, code};     end
    endcase
    return s;
  endfunction

  // ---------------- event capture / FIFO push ----------------
  logic              init_q, prev_q;
  logic [23:0]       push_b_q, push_b_d;
  logic [1:0]        push_n_q, push_n_d;
  ev_seq_t           pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              ovf_q, ovf_d;
  logic              evt, evt_taken, cand_vld, wr_en;
  ev_seq_t           evt_seq, cand;

  logic [7:0]        mem_q [DEPTH];
  logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, count;
  logic [FIFO_AW+1:0] free_slots;
  logic              empty, pop;
  logic [7:0]        head;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign wr_en = (push_n_q != 2'd0);
  // Slots left once this cycle's write lands; a pop this cycle is ignored (conservative).
  assign free_slots = (FIFO_AW+2)'(DEPTH) - {1'b0, count} - {{(FIFO_AW+1){1'b0}}, wr_en};

  always_comb begin
    evt       = init_q && (ps2_key[10] != prev_q);
    evt_seq   = mk_seq(ps2_key[8], ps2_key[9], ps2_key[7:0]);
    push_b_d  = push_b_q;
    push_n_d  = push_n_q;
    pend_d    = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d     = 1'b0;
    evt_taken = 1'b0;
    cand      = evt_seq;
    cand_vld  = 1'b0;
    if (wr_en) begin
      push_b_d = {8'h00, push_b_q[23:8]};
      push_n_d = push_n_q - 2'd1;
    end
    // Pusher free after this cycle: start the oldest waiting event.
    if (push_n_q <= 2'd1) begin
      if (pend_vld_q) begin
        cand = pend_q; cand_vld = 1'b1; pend_vld_d = 1'b0;
      end else if (evt) begin
        cand = evt_seq; cand_vld = 1'b1; evt_taken = 1'b1;
      end
    end
    // Events are atomic: all bytes fit or the whole event is dropped.
    if (cand_vld) begin
      if (free_slots >= (FIFO_AW+2)'(cand.len)) begin
        push_b_d = cand.bytes;
        push_n_d = cand.len;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (evt && !evt_taken) begin
      if (pend_vld_d) ovf_d = 1'b1;
      else begin
        pend_d     = evt_seq;
        pend_vld_d = 1'b1;
      end
    end
  end

  // ---------------- transmit FSM ----------------
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [10:0]   frame_q, frame_d;
  logic          div_last;

  assign div_last = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = '0;
    frame_d = frame_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ps2_clk_in && ps2_data_in)
          hold_d = (hold_q == HW'(HOLDOFF)) ? hold_q : hold_q + HW'(1);
        if (!empty && hold_q == HW'(HOLDOFF)) begin
          state_d = S_HIGH;
          div_d   = '0;
          bit_d   = 4'd0;
          frame_d = {1'b1, ~^head, head, 1'b0};
          hold_d  = '0;
        end
      end
      S_HIGH: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ps2_clk_in ? S_LOW : S_ABORT;
        end else div_d = div_q + DW'(1);
      end
      S_LOW: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 4'd10) begin
            pop     = 1'b1;
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = S_HIGH;
          end
        end else div_d = div_q + DW'(1);
      end
      S_GAP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else div_d = div_q + DW'(1);
      end
      S_ABORT: begin
        div_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset releases the lines asynchronously.
  assign ps2_clk_out  = (state_q != S_LOW);
  assign ps2_data_out = (state_q == S_HIGH || state_q == S_LOW) ? frame_q[bit_q] : 1'b1;
  assign busy         = (state_q != S_IDLE) || !empty;
  assign overflow     = ovf_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      init_q     <= 1'b0;
      prev_q     <= 1'b0;
      push_b_q   <= '0;
      push_n_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      hold_q     <= '0;
      frame_q    <= '1;
    end else begin
      init_q     <= 1'b1;
      prev_q     <= ps2_key[10];
      push_b_q   <= push_b_d;
      push_n_q   <= push_n_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      hold_q     <= hold_d;
      frame_q    <= frame_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_b_q[7:0];
  end

endmodule

// File: tb/tb_ps2_key_dev_tx.sv
module tb_ps2_key_dev_tx;
  localparam int CLK_DIV = 4;
  localparam int HOLDOFF = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        host_clk = 1'b1, host_data = 1'b1;
  logic        ps2_clk_in, ps2_data_in, ps2_clk_out, ps2_data_out, busy, overflow;

  // Open-collector lines: either side can pull low.
  assign ps2_clk_in  = host_clk  & ps2_clk_out;
  assign ps2_data_in = host_data & ps2_data_out;

  ps2_key_dev_tx #(.CLK_DIV(CLK_DIV), .HOLDOFF(HOLDOFF), .FIFO_AW(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out),
    .busy(busy), .overflow(overflow));

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  int checks = 0, errors = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, min);
    end
  endtask

  // start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] frm(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // ---------------- monitor: decode frames on clk_out falling edges ----------------
  logic        prev_clk = 1'b1;
  int          nbits = 0, hi_run = 0, t_first = 0, last_fall = -1, frames = 0, ovf_cnt = 0;
  logic [10:0] sh = '0;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      nbits = 0; hi_run = 0; prev_clk = 1'b1; last_fall = -1;
    end else begin
      if (overflow) ovf_cnt++;
      if (ps2_clk_out) begin
        hi_run++;
        if (hi_run > 6 && nbits != 0) nbits = 0;   // aborted frame, discard
      end else hi_run = 0;
      if (prev_clk && !ps2_clk_out) begin
        if (nbits == 0) begin
          t_first = cyc;
          if (last_fall >= 0) chk_min("inter_frame_gap", cyc - last_fall, 20);
        end
        sh = {ps2_data_out, sh[10:1]};
        nbits++;
        if (nbits == 11) begin
          frames++;
          chk("frame_len", cyc - t_first, 10 * 2 * CLK_DIV);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got %0h expected none", sh);
          end else chk("frame_bits", sh, exp_q.pop_front());
          nbits = 0;
          last_fall = cyc;
        end
      end
      prev_clk = ps2_clk_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic prs, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], prs, ext, code};
    tick(1);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick(1); n++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic wait_bits(input string name, input int nb, input logic clk_lvl);
    int n = 0;
    while (!(nbits == nb && ps2_clk_out == clk_lvl) && n < 1000) begin
      tick(1); n++;
    end
    chk({name, "_reached"}, (n < 1000), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0;
    tick(3);
    chk("rst_clk_out", ps2_clk_out, 1);
    chk("rst_data_out", ps2_data_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    tick(20);

    // 1: make 1C -> bits 0,0,0,1,1,1,0,0,0,0,1
    exp_q.push_back(11'h438);
    send(1'b1, 1'b0, 8'h1C);
    drain("t1", 400);

    // 2: extended break 14 -> E0 F0 14
    exp_q.push_back(frm(8'hE0)); exp_q.push_back(frm(8'hF0)); exp_q.push_back(frm(8'h14));
    send(1'b0, 1'b1, 8'h14);
    drain("t2", 800);

    // second event lands while the first is still being pushed
    exp_q.push_back(frm(8'hE0)); exp_q.push_back(frm(8'hF0)); exp_q.push_back(frm(8'h75));
    exp_q.push_back(frm(8'h29));
    send(1'b0, 1'b1, 8'h75);
    send(1'b1, 1'b0, 8'h29);
    drain("t2b", 1000);

    // 3: inhibit, three 3-byte events; third does not fit
    host_clk = 1'b0;
    f0 = frames; o0 = ovf_cnt;
    exp_q.push_back(frm(8'hE0)); exp_q.push_back(frm(8'hF0)); exp_q.push_back(frm(8'h11));
    exp_q.push_back(frm(8'hE0)); exp_q.push_back(frm(8'hF0)); exp_q.push_back(frm(8'h12));
    send(1'b0, 1'b1, 8'h11); tick(4);
    send(1'b0, 1'b1, 8'h12); tick(4);
    chk("t3_no_ovf_yet", ovf_cnt - o0, 0);
    send(1'b0, 1'b1, 8'h13); tick(4);
    chk("t3_ovf_pulse", ovf_cnt - o0, 1);
    chk("t3_busy", busy, 1);
    tick(50);
    chk("t3_inhibited", frames - f0, 0);
    host_clk = 1'b1;
    drain("t3", 1500);
    chk("t3_frames", frames - f0, 6);

    // 4: inhibit during HIGH phase of bit 5 (frame bit 5 = data[4] = 0)
    f0 = frames;
    exp_q.push_back(frm(8'h4A));
    send(1'b1, 1'b0, 8'h4A);
    wait_bits("t4", 5, 1'b1);
    host_clk = 1'b0;
    tick(CLK_DIV + 1);
    chk("t4_clk_released", ps2_clk_out, 1);
    chk("t4_data_released", ps2_data_out, 1);
    chk("t4_busy", busy, 1);
    chk("t4_no_frame", frames - f0, 0);
    tick(5);
    host_clk = 1'b1;
    drain("t4", 600);
    chk("t4_frames", frames - f0, 1);

    // 5: reset during LOW phase of bit 2
    send(1'b1, 1'b0, 8'h5A);
    wait_bits("t5", 3, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t5_clk_out", ps2_clk_out, 1);
    chk("t5_data_out", ps2_data_out, 1);
    chk("t5_busy", busy, 0);
    // 6: toggle bit already 1 at reset release -> no event
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    tick(3);
    reset_n = 1'b1;
    f0 = frames;
    tick(300);
    chk("t5_no_frames", frames - f0, 0);
    chk("t5_idle", busy, 0);
    exp_q.push_back(frm(8'h1C));
    ps2_key = {1'b0, 1'b1, 1'b0, 8'h1C};
    tick(1);
    drain("t6", 400);
    chk("t6_one_frame", frames - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
